// File: rtl/call_stack_pkg.sv
// Shared constants for the call stack: full-push policy encodings.
package call_stack_pkg;
    localparam int OVF_BLOCK = 0;
    localparam int OVF_WRAP  = 1;
endpackage

// File: rtl/call_stack_mem.sv
// Entry storage for the call stack: one synchronous write port, one combinational read port.
module stack_mem
    import call_stack_pkg::*;
#(
    parameter int DATA_W = 12,
    parameter int DEPTH  = 8,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              wr_en,
    input  logic [AW-1:0]     wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic [AW-1:0]     rd_addr,
    output logic [DATA_W-1:0] rd_data
);

    logic [DATA_W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    assign rd_data = mem[rd_addr];

endmodule

// File: rtl/call_stack.sv
// Circular-buffer call stack with base/count pointers, selectable full-push policy and sticky error flags.
module call_stack
    import call_stack_pkg::*;
#(
    parameter int DATA_W   = 12,
    parameter int DEPTH    = 8,
    parameter int OVF_MODE = OVF_BLOCK,
    localparam int AW      = $clog2(DEPTH),
    localparam int CW      = $clog2(DEPTH + 1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              push,
    input  logic              pop,
    input  logic [DATA_W-1:0] din,
    input  logic              clr_err,
    output logic [DATA_W-1:0] dout,
    output logic [CW-1:0]     count,
    output logic              empty,
    output logic              full,
    output logic              stack_overflow,
    output logic              stack_underflow
);

    logic [AW-1:0]     base;
    logic [AW-1:0]     base_next;
    logic [CW-1:0]     count_next;
    logic [CW-1:0]     next_sum;
    logic [CW-1:0]     top_sum;
    logic [AW-1:0]     next_idx;
    logic [AW-1:0]     top_idx;
    logic              wr_en;
    logic [AW-1:0]     wr_addr;
    logic [DATA_W-1:0] rd_data;
    logic              ovf_evt;
    logic              udf_evt;

    // DEPTH is a power of two, so dropping the carry bit is the modulo.
    assign next_sum = CW'(base) + count;
    assign top_sum  = next_sum - CW'(1);
    assign next_idx = next_sum[AW-1:0];
    assign top_idx  = top_sum[AW-1:0];

    assign empty = (count == '0);
    assign full  = (count == CW'(DEPTH));
    assign dout  = empty ? '0 : rd_data;

    always_comb begin
        base_next  = base;
        count_next = count;
        wr_en      = 1'b0;
        wr_addr    = next_idx;
        ovf_evt    = 1'b0;
        udf_evt    = 1'b0;
        if (push && pop && !empty) begin
            wr_en   = 1'b1;
            wr_addr = top_idx;
        end else if (push) begin
            if (!full) begin
                wr_en      = 1'b1;
                wr_addr    = next_idx;
                count_next = count + CW'(1);
            end else begin
                ovf_evt = 1'b1;
                if (OVF_MODE == OVF_WRAP) begin
                    // Oldest entry is sacrificed: write over it and advance the base.
                    wr_en     = 1'b1;
                    wr_addr   = base;
                    base_next = base + AW'(1);
                end
            end
        end else if (pop) begin
            if (empty) begin
                udf_evt = 1'b1;
            end else begin
                count_next = count - CW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            base            <= '0;
            count           <= '0;
            stack_overflow  <= 1'b0;
            stack_underflow <= 1'b0;
        end else begin
            base  <= base_next;
            count <= count_next;
            // A new error event takes priority over a simultaneous clear.
            if (ovf_evt) begin
                stack_overflow <= 1'b1;
            end else if (clr_err) begin
                stack_overflow <= 1'b0;
            end
            if (udf_evt) begin
                stack_underflow <= 1'b1;
            end else if (clr_err) begin
                stack_underflow <= 1'b0;
            end
        end
    end

    stack_mem #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_mem (
        .clk     (clk),
        .wr_en   (wr_en),
        .wr_addr (wr_addr),
        .wr_data (din),
        .rd_addr (top_idx),
        .rd_data (rd_data)
    );

endmodule
